// File: rtl/uart_pwm_pkg.sv
`default_nettype none
// ============================================================================
// uart_pwm_pkg : shared states, ASCII constants and opcode helpers for the
//                UART command controller.
// Revision     : 1.0
// ============================================================================
package uart_pwm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NUM   = 3'd1,
    FLUSH = 3'd2,
    APPLY = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam int          ACC_W      = 27;
  localparam int          DUTY_MAX   = 100;

  localparam logic [7:0]  ASCII_ACK  = 8'h4B;  // 'K'
  localparam logic [7:0]  ASCII_NAK  = 8'h45;  // 'E'
  localparam logic [7:0]  ASCII_CR   = 8'h0D;
  localparam logic [7:0]  OP_FREQ_U  = 8'h46;  // 'F'
  localparam logic [7:0]  OP_FREQ_L  = 8'h66;  // 'f'
  localparam logic [7:0]  OP_DUTY_U  = 8'h44;  // 'D'
  localparam logic [7:0]  OP_DUTY_L  = 8'h64;  // 'd'

  function automatic logic is_freq_op(input logic [7:0] b);
    return (b == OP_FREQ_U) || (b == OP_FREQ_L);
  endfunction

  function automatic logic is_duty_op(input logic [7:0] b);
    return (b == OP_DUTY_U) || (b == OP_DUTY_L);
  endfunction

endpackage : uart_pwm_pkg
`default_nettype wire

// File: rtl/uart_dec_accum.sv
`default_nettype none
// ============================================================================
// uart_dec_accum : ASCII decimal digit detector and base-10 accumulator with
//                  digit counter and full flag.
// Revision       : 1.0
// ============================================================================
module uart_dec_accum
  import uart_pwm_pkg::*;
#(
  parameter int MAX_DIGITS = 8,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [7:0]       din,
  output logic             is_digit,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  logic [ACC_W-1:0] digit_val;
  logic [ACC_W-1:0] acc_next;

  assign is_digit  = (din >= 8'h30) && (din <= 8'h39);
  assign digit_val = ACC_W'(din[3:0]);
  // acc*10 + d as two shifts and adds, no multiplier needed
  assign acc_next  = (acc << 3) + (acc << 1) + digit_val;
  assign full      = (count == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (step) begin
      acc   <= acc_next;
      count <= count + 1'b1;
    end
  end

endmodule : uart_dec_accum
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// uart_cmd_ctrl : parses "<op><digits><EOS>" commands from the UART receiver,
//                 updates PWM frequency/duty and answers 'K' or 'E'.
// Revision      : 1.0
// ============================================================================
module uart_cmd_ctrl
  import uart_pwm_pkg::*;
#(
  parameter int unsigned MAX_FREQ_HZ     = 1_000_000,
  parameter int unsigned MIN_FREQ_HZ     = 1,
  parameter int unsigned DEFAULT_FREQ_HZ = 1000,
  parameter int unsigned DEFAULT_DUTY    = 50,
  parameter logic [7:0]  EOS_CHAR        = 8'h0A,
  parameter int          MAX_DIGITS      = 8
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [23:0] freq_hz,
  output logic [6:0]  duty_pct,
  output logic        cfg_update,
  output logic        rx_drop
);

  localparam int               CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam logic [ACC_W-1:0] F_MIN  = ACC_W'(MIN_FREQ_HZ);
  localparam logic [ACC_W-1:0] F_MAX  = ACC_W'(MAX_FREQ_HZ);
  localparam logic [ACC_W-1:0] D_MAX  = ACC_W'(DUTY_MAX);

  state_t           state;
  logic             op_freq;
  logic             is_digit;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             is_op;
  logic             acc_clear;
  logic             acc_step;
  logic             arg_ok;

  assign is_op     = is_freq_op(rx_data) || is_duty_op(rx_data);
  assign acc_clear = (state == IDLE) && rx_valid && is_op;
  assign acc_step  = (state == NUM) && rx_valid && is_digit && !full;

  uart_dec_accum #(
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) u_accum (
    .clk      (clk_50mhz),
    .rst      (rst),
    .clear    (acc_clear),
    .step     (acc_step),
    .din      (rx_data),
    .is_digit (is_digit),
    .acc      (acc),
    .count    (count),
    .full     (full)
  );

  always_comb begin
    arg_ok = 1'b0;
    if (count != '0) begin
      if (op_freq) arg_ok = (acc >= F_MIN) && (acc <= F_MAX);
      else         arg_ok = (acc <= D_MAX);
    end
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_freq    <= 1'b0;
      freq_hz    <= 24'(DEFAULT_FREQ_HZ);
      duty_pct   <= 7'(DEFAULT_DUTY);
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      cfg_update <= 1'b0;
      rx_drop    <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      rx_drop    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_valid && rx_data != ASCII_CR) begin
            if (is_op) begin
              op_freq <= is_freq_op(rx_data);
              state   <= NUM;
            end else if (rx_data != EOS_CHAR) begin
              state   <= FLUSH;
            end
          end
        end
        NUM: begin
          if (rx_valid && rx_data != ASCII_CR) begin
            if (is_digit) begin
              if (full) state <= FLUSH;
            end else if (rx_data == EOS_CHAR) begin
              state <= APPLY;
            end else begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (rx_valid && rx_data == EOS_CHAR) begin
            tx_data  <= ASCII_NAK;
            tx_valid <= 1'b1;
            state    <= RESP;
          end
        end
        APPLY: begin
          rx_drop  <= rx_valid;
          tx_valid <= 1'b1;
          state    <= RESP;
          if (arg_ok) begin
            if (op_freq) freq_hz  <= acc[23:0];
            else         duty_pct <= acc[6:0];
            cfg_update <= 1'b1;
            tx_data    <= ASCII_ACK;
          end else begin
            tx_data    <= ASCII_NAK;
          end
        end
        RESP: begin
          rx_drop <= rx_valid;
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : uart_cmd_ctrl
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_ctrl : table vectors, corner sequences and random commands
//                    checked against a string-level command model.
// Revision         : 1.0
// ============================================================================
module tb_uart_cmd_ctrl;

  typedef logic [7:0] u8;

  typedef struct {
    string      cmd;
    logic [7:0] st;
    int         freq;
    int         duty;
    int         upd;
  } vec_t;

  logic        clk_50mhz;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [23:0] freq_hz;
  logic [6:0]  duty_pct;
  logic        cfg_update;
  logic        rx_drop;

  int nerr = 0;
  int nchk = 0;
  int cfg_cnt = 0;
  int drop_cnt = 0;
  int m_freq = 1000;
  int m_duty = 50;

  uart_cmd_ctrl dut (
    .clk_50mhz  (clk_50mhz),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .freq_hz    (freq_hz),
    .duty_pct   (duty_pct),
    .cfg_update (cfg_update),
    .rx_drop    (rx_drop)
  );

  initial clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  always @(negedge clk_50mhz) begin
    if (cfg_update) cfg_cnt++;
    if (rx_drop)    drop_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: strip CRs and the terminator, then apply the command rules.
  function automatic void model(input u8 q[$], output logic [7:0] st, output bit upd);
    u8      t[$];
    bit     isf, isd;
    longint val;
    int     nd;
    t = {};
    foreach (q[i]) if (q[i] != 8'h0D) t.push_back(q[i]);
    while (t.size() > 0 && t[0] == 8'h0A) void'(t.pop_front());
    if (t.size() > 0 && t[t.size()-1] == 8'h0A) void'(t.pop_back());
    st  = 8'h45;
    upd = 1'b0;
    if (t.size() == 0) return;
    isf = (t[0] == 8'h46) || (t[0] == 8'h66);
    isd = (t[0] == 8'h44) || (t[0] == 8'h64);
    if (!isf && !isd) return;
    nd = t.size() - 1;
    if (nd < 1 || nd > 8) return;
    val = 0;
    for (int i = 1; i < t.size(); i++) begin
      if (t[i] < 8'h30 || t[i] > 8'h39) return;
      val = val * 10 + longint'(t[i] - 8'h30);
    end
    if (isf && (val < 1 || val > 1000000)) return;
    if (isd && val > 100) return;
    if (isf) m_freq = int'(val);
    else     m_duty = int'(val);
    st  = 8'h4B;
    upd = 1'b1;
  endfunction

  task automatic send_byte(input u8 b);
    @(posedge clk_50mhz); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk_50mhz); #1;
    rx_valid = 1'b0;
  endtask

  task automatic run_bytes(input string name, input u8 q[$], input logic [7:0] est,
                           input int ef, input int ed, input int eupd);
    int c0;
    int n;
    bit seen;
    c0       = cfg_cnt;
    tx_ready = 1'b1;
    foreach (q[i]) send_byte(q[i]);
    seen = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk_50mhz);
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk({name, " response timeout"}, 0, 1);
    end else begin
      chk({name, " status"}, tx_data, est);
      if (eupd != 0) begin
        chk({name, " tx latency"}, n, 1);
        chk({name, " freq at tx"}, freq_hz, ef);
      end
      @(negedge clk_50mhz);
      chk({name, " tx_valid cleared"}, tx_valid, 0);
    end
    chk({name, " freq_hz"}, freq_hz, ef);
    chk({name, " duty_pct"}, duty_pct, ed);
    chk({name, " cfg_update count"}, cfg_cnt - c0, eupd);
  endtask

  vec_t tbl[16];

  initial begin
    u8          q[$];
    logic [7:0] st;
    bit         upd;
    int         d0;
    int         hs;
    bit         seen;

    tbl[0]  = '{"D101\n",       8'h45, 1000,    50,  0};
    tbl[1]  = '{"F0\n",         8'h45, 1000,    50,  0};
    tbl[2]  = '{"F1000001\n",   8'h45, 1000,    50,  0};
    tbl[3]  = '{"F2000\n",      8'h4B, 2000,    50,  1};
    tbl[4]  = '{"d75\r\n",      8'h4B, 2000,    75,  1};
    tbl[5]  = '{"X12\n",        8'h45, 2000,    75,  0};
    tbl[6]  = '{"F12a4\n",      8'h45, 2000,    75,  0};
    tbl[7]  = '{"F123456789\n", 8'h45, 2000,    75,  0};
    tbl[8]  = '{"F5\n",         8'h4B, 5,       75,  1};
    tbl[9]  = '{"D007\n",       8'h4B, 5,       7,   1};
    tbl[10] = '{"F1000000\n",   8'h4B, 1000000, 7,   1};
    tbl[11] = '{"D100\n",       8'h4B, 1000000, 100, 1};
    tbl[12] = '{"D\n",          8'h45, 1000000, 100, 0};
    tbl[13] = '{"f\r1\n",       8'h4B, 1,       100, 1};
    tbl[14] = '{"\nD30\n",      8'h4B, 1,       30,  1};
    tbl[15] = '{"D0\n",         8'h4B, 1,       0,   1};

    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    chk("reset freq_hz", freq_hz, 1000);
    chk("reset duty_pct", duty_pct, 50);
    chk("reset tx_valid", tx_valid, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset cfg_update", cfg_update, 0);
    chk("reset rx_drop", rx_drop, 0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      q = {};
      for (int i = 0; i < tbl[k].cmd.len(); i++) q.push_back(tbl[k].cmd[i]);
      model(q, st, upd);
      run_bytes($sformatf("vec%0d", k), q, tbl[k].st, tbl[k].freq, tbl[k].duty, tbl[k].upd);
    end

    // Back-pressure: response held, extra byte dropped, single handshake.
    tx_ready = 1'b0;
    q = '{8'h44, 8'h31, 8'h30, 8'h0A};
    model(q, st, upd);
    foreach (q[i]) send_byte(q[i]);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_50mhz);
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp tx_valid seen", seen, 1);
    d0 = drop_cnt;
    send_byte(8'h46);
    repeat (3) @(negedge clk_50mhz);
    chk("bp rx_drop count", drop_cnt - d0, 1);
    chk("bp tx_valid held", tx_valid, 1);
    chk("bp tx_data held", tx_data, 8'h4B);
    chk("bp duty_pct", duty_pct, 10);
    @(posedge clk_50mhz); #1;
    tx_ready = 1'b1;
    hs = 0;
    repeat (5) begin
      @(negedge clk_50mhz);
      if (tx_valid && tx_ready) hs++;
    end
    chk("bp handshakes", hs, 1);
    q = '{8'h44, 8'h32, 8'h30, 8'h0A};
    model(q, st, upd);
    run_bytes("after bp D20", q, st, m_freq, m_duty, int'(upd));

    // Randomized commands against the model.
    for (int r = 0; r < 40; r++) begin
      int sel;
      int len;
      bit fop;
      q   = {};
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: q.push_back(8'h46);
        3:       q.push_back(8'h66);
        4, 5, 6: q.push_back(8'h44);
        7:       q.push_back(8'h64);
        8:       q.push_back(8'h58);
        default: q.push_back(8'h37);
      endcase
      fop = (sel <= 3);
      len = fop ? $urandom_range(0, 9) : $urandom_range(0, 3);
      for (int i = 0; i < len; i++) q.push_back(u8'($urandom_range(0, 9) + 48));
      if ($urandom_range(0, 7) == 0) q.insert($urandom_range(1, q.size()), 8'h2E);
      if ($urandom_range(0, 5) == 0) q.insert($urandom_range(1, q.size()), 8'h0D);
      q.push_back(8'h0A);
      model(q, st, upd);
      run_bytes($sformatf("rand%0d", r), q, st, m_freq, m_duty, int'(upd));
    end

    // Reset in the middle of a command.
    send_byte(8'h46);
    send_byte(8'h31);
    send_byte(8'h32);
    @(posedge clk_50mhz); #2;
    rst = 1'b1;
    #1;
    chk("midrst freq_hz", freq_hz, 1000);
    chk("midrst duty_pct", duty_pct, 50);
    chk("midrst tx_valid", tx_valid, 0);
    repeat (2) @(negedge clk_50mhz);
    rst    = 1'b0;
    m_freq = 1000;
    m_duty = 50;
    q = '{8'h46, 8'h33, 8'h30, 8'h30, 8'h0A};
    model(q, st, upd);
    run_bytes("post reset F300", q, 8'h4B, 300, 50, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule : tb_uart_cmd_ctrl
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command controller between the UART receiver and the PWM generator.
- Consumes the received byte stream (rx_data/rx_valid), parses ASCII commands terminated by an end-of-string character, and range-checks the argument.
- Updates the PWM configuration registers, then returns a one-byte status ('K' ok / 'E' error) to the UART transmitter through a valid/ready handshake.

Parameters:
MAX_FREQ_HZ, 1_000_000, largest legal frequency argument.
MIN_FREQ_HZ, 1, smallest legal frequency argument.
DEFAULT_FREQ_HZ, 1000, freq_hz value after reset.
DEFAULT_DUTY, 50, duty_pct value after reset.
EOS_CHAR, 8'h0A, command terminator.
MAX_DIGITS, 8, maximum decimal digits accepted per argument.

Ports:
clk_50mhz  in  1  system clock, 50 MHz.
rst  in  1  asynchronous, active-high reset.
rx_data  in  8  received byte, valid when rx_valid=1.
rx_valid  in  1  single-cycle strobe, one per received byte.
tx_data  out  8  status byte to the UART transmitter.
tx_valid  out  1  tx_data valid; held until accepted.
tx_ready  in  1  transmitter accepts tx_data when tx_valid & tx_ready.
freq_hz  out  24  current PWM frequency setting in Hz.
duty_pct  out  7  current PWM duty setting, 0..100.
cfg_update  out  1  one-cycle pulse when freq_hz or duty_pct changes.
rx_drop  out  1  one-cycle pulse when a byte arrives while busy and is discarded.

Behaviour:
- Reset (async assert, sync release): state=IDLE, freq_hz=DEFAULT_FREQ_HZ, duty_pct=DEFAULT_DUTY, tx_valid=0, tx_data=0, cfg_update=0, rx_drop=0, accumulator=0, digit count=0.
- Command syntax: opcode byte, decimal digits, EOS_CHAR.
  - Opcode 'F'/'f' selects frequency; 'D'/'d' selects duty.
  - 8'h0D (CR) is ignored in every receiving state.
- States:
  - IDLE: on rx_valid with an opcode, latch the opcode, clear the accumulator, go to NUM. On EOS_CHAR, stay in IDLE and send nothing (empty line). Any other byte goes to FLUSH.
  - NUM: on a digit 0x30..0x39, acc <= acc*10 + digit and increment the count. If the digit would exceed MAX_DIGITS, go to FLUSH. On EOS_CHAR, go to APPLY. Any other byte goes to FLUSH.
  - FLUSH: discard bytes until EOS_CHAR, then set status='E' and go to RESP.
  - APPLY (1 cycle):
    - Error if digit count==0, 'F' with acc outside MIN..MAX_FREQ_HZ, or 'D' with acc>100.
    - On error: status='E', no register change.
    - Otherwise: write the register and pulse cfg_update in the same cycle. cfg_update pulses even if the value is unchanged. status='K'.
    - Next state is RESP.
  - RESP: tx_valid=1 and tx_data=status, held stable until tx_valid&tx_ready, then IDLE the following cycle with tx_valid=0.
- Arithmetic:
  - Accumulator is 27 bits (enough for 8 decimal digits).
  - freq_hz takes acc[23:0] only after the range check.
- Timing: the new freq_hz/duty_pct appears 2 cycles after the rx_valid of EOS_CHAR. tx_valid asserts in the cycle after APPLY.
- Boundaries:
  - rx_valid during APPLY or RESP: the byte is dropped and rx_drop pulses in that cycle. The state is unaffected.
  - tx_ready held high: the handshake completes in the first RESP cycle.
  - tx_ready low indefinitely: remain in RESP.
  - Leading zeros are legal ("D007" gives 7).
  - Reset mid-command: discards the partial command; registers return to their defaults.

Decomposition:
- Package uart_pwm_pkg holds:
  - state enum (IDLE, NUM, FLUSH, APPLY, RESP);
  - ASCII constants: ACK 'K'=8'h4B, NAK 'E'=8'h45, CR 8'h0D, opcodes 'F'/'D' and their lower-case forms;
  - DUTY_MAX=100.
- One natural sub-module: uart_dec_accum, holding the digit detect, the acc*10+d update (shift-add: acc<<3 + acc<<1 + d), the digit counter and the overflow flag.

Test Plan:
- Send "F2000\n" -> freq_hz=2000, one cfg_update pulse, tx_data=8'h4B accepted, duty_pct stays 50.
- Send "d75\r\n" with tx_ready=1 -> duty_pct=75, 'K' returned.
- Send "D101\n", then "F0\n", then "F1000001\n" -> three 'E' responses; freq_hz=1000 and duty_pct=50 unchanged; no cfg_update.
- Send "X12\n", then "F12a4\n", then "F123456789\n" (9 digits) -> 'E' each time, with FLUSH consuming up to the newline. A following "F5\n" -> freq_hz=5, 'K'.
- Hold tx_ready=0 after "D10\n", then inject rx_valid with 8'h46 -> rx_drop pulses, tx_valid stays high with 'K'. Release tx_ready -> one handshake, back to IDLE. The next "D20\n" is parsed correctly.
- Assert rst mid-"F12" -> freq_hz=1000, duty_pct=50, tx_valid=0 immediately. After release, "F300\n" -> freq_hz=300.
